clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider producing a 50%-duty output for both odd and even divisors.
- Odd divisors use a negedge-retimed copy of the posedge phase signal.
- Successor to the fixed divide-by-3 divider. Adds:
  - parametrised counter width;
  - divisor changes applied glitch-free at period boundaries;
  - divide-by-1 bypass;
  - enable with clean stop;
  - per-period tick.
- Sits in the clock-generation area and feeds local derived-clock domains.

Parameters:
- CNT_W, 8, width of divisor input and period counter; max divisor 2^CNT_W-1.
- DIV_RST, 3, active divisor loaded at reset; must be in range 0..2^CNT_W-1.

Ports:
- clk  input  1  source clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request; sampled on posedge clk.
- div_i  input  CNT_W  requested divisor N; 0 and 1 both mean bypass.
- clk_out  output  1  divided clock.
- tick  output  1  registered one-clk pulse in first cycle of each output period.
- div_act  output  CNT_W  divisor currently in effect.
- running  output  1  high while divider is producing periods.

Behaviour:
- Reset (rst_n low, async):
  - cnt=0, q_pos=0, q_neg=0, tick=0, running=0, div_act=DIV_RST.
  - clk_out=0 regardless of div_act.
- State: IDLE / RUN, held in register running.
- Counter:
  - cnt counts 0..Nact-1 on posedge and wraps to 0.
  - cnt==Nact-1 is the period boundary. In bypass every cycle is a boundary.
- Half point: H = (Nact+1)>>1, computed in CNT_W+1 bits so no overflow at max N.
  - q_pos (posedge reg) <= 1 when next cnt < H, else 0.
- q_neg (negedge reg) <= q_pos. Reset asynchronously by rst_n.
- clk_out:
  - bypass (Nact<=1): clk & running.
  - even Nact: q_pos.
  - odd Nact>=3: q_pos & q_neg.
- Odd timing: high for (Nact/2) clk periods exactly (e.g. 1.5 for N=3, 2.5 for N=5). Rising edge at clk negedge, falling edge at clk posedge.
- Even timing: high Nact/2 cycles, low Nact/2 cycles. Both edges on clk posedge.
- Divisor load:
  - div_i is sampled into div_act only at a boundary posedge, or on the posedge leaving IDLE.
  - Changes mid-period are ignored until the next boundary.
  - The last value present at the boundary wins.
- IDLE->RUN:
  - Transition on the first posedge with en=1.
  - On that edge: div_act<=div_i, cnt<=0, q_pos<=1, tick<=1.
- RUN->IDLE:
  - en is sampled only at boundaries.
  - If en=0 at a boundary: running<=0, cnt<=0, q_pos<=0, tick<=0.
  - The current period always completes. clk_out ends low with no runt pulse.
- tick:
  - Asserted for the clk cycle in which cnt==0 of a period in RUN.
  - In bypass, tick stays high every cycle while running.
- Bypass transitions:
  - Entering or leaving bypass happens only at a boundary, where the divided clk_out is low.
  - The mux switch coincides with a clk rising edge.
- en and div_i changing on the same boundary edge: en=0 takes priority. div_act is still updated to div_i.
- Reset mid-period: clk_out drops to 0 immediately. Restart follows the IDLE->RUN rules.
- div_i, en: synchronous to clk. No CDC inside the block.

Test Plan:
- Reset, en=1, div_i=3 -> first period starts next posedge.
  - clk_out high 1.5 clk periods, low 1.5 clk periods, repeating.
  - tick every 3rd cycle; div_act=3.
- div_i=4, then div_i=7, then div_i=255 -> exact counts and duty:
  - 2 high / 2 low;
  - 3.5 high / 3.5 low;
  - 127.5 high / 127.5 low.
  - Period measured over 4 periods each.
- Running N=3; change div_i to 6 at cnt=1 -> current period finishes at 3 cycles. Next period is 6 cycles (3 high/3 low). No glitch or runt pulse. div_act changes at the boundary.
- div_i=1, then div_i=0 -> clk_out follows clk; tick constantly high.
  - Switch to div_i=2 -> first divided period starts at the boundary.
  - clk_out shows no pulse narrower than half a clk.
- Running N=5; en=0 mid-period -> the 5-cycle period completes, then clk_out=0, running=0.
  - en=1 again -> restart with tick=1 on the first edge.
- Running N=5; assert rst_n=0 during the high phase -> clk_out=0 immediately.
  - After release, div_act=DIV_RST, cnt=0, and normal restart follows.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Runtime-programmable integer clock divider with 50% duty for
//               odd and even divisors, divide-by-1 bypass, clean enable stop,
//               glitch-free divisor changes at period boundaries and a
//               per-period tick.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_i,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_act,
    output logic             running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   C_ONE_W = (CNT_W+1)'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W:0]   half;
    logic             q_pos;
    logic             q_pos_nxt;
    logic             q_neg;
    logic             tick_nxt;
    logic             bypass;
    logic             req_bypass;
    logic             boundary;

    // Period arithmetic on the divisor currently in effect. The half point is
    // one bit wider so that (2^CNT_W-1)+1 does not wrap.
    always_comb begin
        cnt_inc    = cnt + C_ONE;
        last_cnt   = div_act - C_ONE;
        half       = ({1'b0, div_act} + C_ONE_W) >> 1;
        bypass     = (div_act <= C_ONE);
        req_bypass = (div_i <= C_ONE);
        boundary   = bypass || (cnt == last_cnt);
    end

    // Next-state and next-register values for the IDLE/RUN controller.
    // At each period start q_pos goes high only for a divided period; in
    // bypass it is held low so that the negedge copy is low when a divided
    // period resumes and an odd divisor still rises on the clk negedge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_act;
        q_pos_nxt = q_pos;
        tick_nxt  = 1'b0;
        if (state == IDLE) begin
            cnt_nxt   = '0;
            q_pos_nxt = 1'b0;
            if (en) begin
                state_nxt = RUN;
                div_nxt   = div_i;
                q_pos_nxt = !req_bypass;
                tick_nxt  = 1'b1;
            end
        end else begin
            if (boundary) begin
                // The last div_i present at the boundary wins, even when
                // the divider is stopping.
                div_nxt = div_i;
                cnt_nxt = '0;
                if (!en) begin
                    state_nxt = IDLE;
                    q_pos_nxt = 1'b0;
                    tick_nxt  = 1'b0;
                end else begin
                    q_pos_nxt = !req_bypass;
                    tick_nxt  = 1'b1;
                end
            end else begin
                cnt_nxt   = cnt_inc;
                q_pos_nxt = ({1'b0, cnt_inc} < half);
                tick_nxt  = 1'b0;
            end
        end
    end

    // Posedge state: controller, counter, active divisor, phase and tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_act <= CNT_W'(DIV_RST);
            q_pos   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_act <= div_nxt;
            q_pos   <= q_pos_nxt;
            tick    <= tick_nxt;
        end
    end

    // Negedge-retimed phase copy, used to stretch odd-divisor high time by
    // half a source period.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    // Output mux: bypass gates the source clock, even divisors use the
    // posedge phase, odd divisors AND both phases.
    always_comb begin
        running = (state == RUN);
        if (bypass) begin
            clk_out = clk & running;
        end else if (div_act[0]) begin
            clk_out = q_pos & q_neg;
        end else begin
            clk_out = q_pos;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Self-checking bench for clk_div_prog. Expected per-cycle
//               output (clk_out in both clk phases, tick, running, div_act)
//               is queued when stimulus is applied and compared as the DUT
//               produces each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    localparam int CNT_W   = 8;
    localparam int DIV_RST = 3;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_i;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] div_act;
    logic             running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             hi;
        logic             lo;
        logic             tk;
        logic             rn;
        logic [CNT_W-1:0] dv;
    } exp_t;

    exp_t exp_q[$];

    clk_div_prog #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_i   (div_i),
        .clk_out (clk_out),
        .tick    (tick),
        .div_act (div_act),
        .running (running)
    );

    // Source clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected cycles for one output period of divisor n.
    task automatic push_period(input int n);
        exp_t e;
        if (n <= 1) begin
            e.hi = 1'b1; e.lo = 1'b0; e.tk = 1'b1; e.rn = 1'b1; e.dv = CNT_W'(n);
            exp_q.push_back(e);
        end else begin
            for (int c = 0; c < n; c++) begin
                e.tk = (c == 0);
                e.rn = 1'b1;
                e.dv = CNT_W'(n);
                if (n % 2 == 0) begin
                    e.hi = (c < n / 2);
                    e.lo = (c < n / 2);
                end else begin
                    e.hi = (c >= 1) && (c <= (n - 1) / 2);
                    e.lo = (c <= (n - 1) / 2);
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_idle(input int k, input int dv);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            e.hi = 1'b0; e.lo = 1'b0; e.tk = 1'b0; e.rn = 1'b0; e.dv = CNT_W'(dv);
            exp_q.push_back(e);
        end
    endtask

    // Consume k clk cycles, sampling mid high phase and mid low phase.
    task automatic step(input int k);
        exp_t             e;
        logic             s_hi, s_lo, s_tk, s_rn;
        logic [CNT_W-1:0] s_dv;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #2;
            s_hi = clk_out; s_tk = tick; s_rn = running; s_dv = div_act;
            @(negedge clk); #2;
            s_lo = clk_out;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL scoreboard_empty: observed %0d entries expected >0", exp_q.size());
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("clk_out_hi", 32'(s_hi), 32'(e.hi));
                chk("clk_out_lo", 32'(s_lo), 32'(e.lo));
                chk("tick",       32'(s_tk), 32'(e.tk));
                chk("running",    32'(s_rn), 32'(e.rn));
                chk("div_act",    32'(s_dv), 32'(e.dv));
            end
        end
    endtask

    // Request divisor n at the next boundary and check `periods` periods.
    task automatic run(input int n, input int periods);
        div_i = CNT_W'(n);
        for (int p = 0; p < periods; p++) push_period(n);
        step(periods * ((n <= 1) ? 1 : n));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        div_i = CNT_W'(3);
        #1;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_div_act", 32'(div_act), 32'(DIV_RST));
        chk("rst_clk_out_rel", 32'(clk_out), 32'd0);

        // Idle with en low: nothing happens.
        push_idle(2, DIV_RST);
        step(2);

        // Start N=3, then even/odd/max divisors.
        en = 1'b1;
        run(3, 4);
        run(4, 4);
        run(7, 4);
        run(255, 4);

        // Mid-period divisor change: current 3-cycle period completes first.
        run(3, 1);
        push_period(3);
        step(2);
        div_i = CNT_W'(6);
        step(1);
        push_period(6);
        push_period(6);
        step(12);

        // Bypass with 1 and 0, then back to a divided clock.
        run(1, 4);
        run(0, 4);
        run(2, 3);

        // Stop mid-period: the period completes, then idle; restart.
        div_i = CNT_W'(5);
        push_period(5);
        step(2);
        en = 1'b0;
        step(3);
        push_idle(3, 5);
        step(3);
        en = 1'b1;
        push_period(5);
        push_period(5);
        step(10);

        // Asynchronous reset during the high phase.
        push_period(5);
        step(1);
        exp_q.delete();
        @(posedge clk); #2;
        chk("pre_rst_high", 32'(clk_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", 32'(clk_out), 32'd0);
        chk("async_rst_running", 32'(running), 32'd0);
        chk("async_rst_tick",    32'(tick),    32'd0);
        chk("async_rst_div_act", 32'(div_act), 32'(DIV_RST));
        @(negedge clk); #2;
        chk("rst_hold_clk_out", 32'(clk_out), 32'd0);
        div_i = CNT_W'(4);
        rst_n = 1'b1;
        #1;
        chk("rel_div_act", 32'(div_act), 32'(DIV_RST));
        push_period(4);
        push_period(4);
        step(8);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
